// File: rtl/oc8051_rom_pkg.sv
// rtl/oc8051_rom_pkg.sv - shared state encoding and limits for the program ROM
package oc8051_rom_pkg;

   localparam int MAX_FETCH = 4;
   localparam int MAX_WAIT  = 3;

   // Wait counter is sized for the largest legal number of wait states
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_LOAD = 2'd2
   } rom_state_e;

endpackage

// File: rtl/oc8051_rom_mem.sv
// rtl/oc8051_rom_mem.sv - byte array with one write port and N registered read ports
module oc8051_rom_mem #(
   parameter int ADDR_W = 8,
   parameter int N_RD   = 3
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        waddr_i,
   input  logic [7:0]               wdata_i,
   input  logic [N_RD*ADDR_W-1:0]   raddr_i,
   output logic [N_RD*8-1:0]        rdata_o
);

   logic [7:0]          mem_q [0:(1<<ADDR_W)-1];
   logic [N_RD*8-1:0]   rdata_q;

   // Write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // One registered read per fetched byte
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_RD; k++) begin
         rdata_q[k*8 +: 8] <= mem_q[raddr_i[k*ADDR_W +: ADDR_W]];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/oc8051_prog_rom.sv
// rtl/oc8051_prog_rom.sv - loadable 8051 program ROM with multi-byte fetch and wait states
module oc8051_prog_rom
   import oc8051_rom_pkg::*;
#(
   parameter int INT_ROM_WID = 8,
   parameter int FETCH_BYTES = 3,
   parameter int WAIT_STATES = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              addr,
   input  logic                     rd,
   output logic                     ea_int,
   output logic [8*FETCH_BYTES-1:0] data,
   output logic                     valid,
   input  logic                     ld_en,
   input  logic                     ld_clr,
   input  logic                     ld_wr,
   input  logic [7:0]               ld_data,
   output logic [INT_ROM_WID-1:0]   ld_ptr,
   output logic [7:0]               ld_sum,
   output logic                     busy
);

   localparam int AW = INT_ROM_WID;
   localparam int DW = 8 * FETCH_BYTES;
   localparam logic [CNT_W-1:0] WS_L    = CNT_W'(WAIT_STATES);
   localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   rom_state_e             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [15:0]            addr_q;
   logic                   valid_q;
   logic                   busy_q;
   logic [DW-1:0]          data_q;
   logic [AW-1:0]          ld_ptr_q, ld_ptr_d;
   logic [7:0]             ld_sum_q, ld_sum_d;

   logic [15:0]            rd_base;
   logic [15:0]            rd_byte_addr;
   logic [15:0]            hit_byte_addr;
   logic [FETCH_BYTES*AW-1:0] mem_raddr;
   logic [DW-1:0]          mem_rdata;
   logic [DW-1:0]          rd_masked;
   logic                   mem_we;
   logic [AW-1:0]          mem_waddr;

   // Internal ROM hit: no address bits above the ROM window are set
   assign ea_int = ((32'(addr) >> AW) == 32'd0);

   // In IDLE the read ports look at the live address so that data is already
   // registered by the time a zero-wait fetch completes; afterwards they hold
   // on the latched address.
   assign rd_base = (state_q == ST_IDLE) ? addr : addr_q;

   // Per-byte read addresses, each wrapping modulo 2^16 before truncation
   always_comb begin
      mem_raddr    = '0;
      rd_byte_addr = '0;
      for (int k = 0; k < FETCH_BYTES; k++) begin
         rd_byte_addr = rd_base + 16'(k);
         mem_raddr[k*AW +: AW] = rd_byte_addr[AW-1:0];
      end
   end

   // Bytes that fall outside the internal window read as zero
   always_comb begin
      rd_masked     = mem_rdata;
      hit_byte_addr = '0;
      for (int k = 0; k < FETCH_BYTES; k++) begin
         hit_byte_addr = addr_q + 16'(k);
         if ((32'(hit_byte_addr) >> AW) != 32'd0) begin
            rd_masked[k*8 +: 8] = 8'h00;
         end
      end
   end

   // Loader writes land at the pointer, or at 0 when a clear arrives with them
   assign mem_we    = (state_q == ST_LOAD) && ld_wr;
   assign mem_waddr = ld_clr ? '0 : ld_ptr_q;

   oc8051_rom_mem #(
      .ADDR_W (AW),
      .N_RD   (FETCH_BYTES)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (ld_data),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   // Loader pointer and running checksum, only active in LOAD
   always_comb begin
      ld_ptr_d = ld_ptr_q;
      ld_sum_d = ld_sum_q;
      if (state_q == ST_LOAD) begin
         if (ld_clr && ld_wr) begin
            ld_ptr_d = PTR_ONE;
            ld_sum_d = ld_data;
         end else if (ld_clr) begin
            ld_ptr_d = '0;
            ld_sum_d = 8'h00;
         end else if (ld_wr) begin
            ld_ptr_d = ld_ptr_q + PTR_ONE;
            ld_sum_d = ld_sum_q + ld_data;
         end
      end
   end

   // Loader registers; the pointer persists across LOAD exits so a load can resume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_ptr_q <= '0;
         ld_sum_q <= 8'h00;
      end else begin
         ld_ptr_q <= ld_ptr_d;
         ld_sum_q <= ld_sum_d;
      end
   end

   // Fetch/load FSM; busy covers LOAD and the inserted wait cycles of a fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= 16'h0000;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ld_en) begin
                  state_q <= ST_LOAD;
                  busy_q  <= 1'b1;
               end else if (rd) begin
                  addr_q  <= addr;
                  cnt_q   <= '0;
                  state_q <= ST_WAIT;
                  busy_q  <= (WS_L != '0);
               end
            end
            ST_WAIT: begin
               if (ld_en) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (cnt_q == WS_L) begin
                  valid_q <= 1'b1;
                  data_q  <= rd_masked;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + 1'b1;
                  busy_q <= ((cnt_q + 1'b1) != WS_L);
               end
            end
            ST_LOAD: begin
               if (!ld_en) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valid  = valid_q;
   assign busy   = busy_q;
   assign data   = data_q;
   assign ld_ptr = ld_ptr_q;
   assign ld_sum = ld_sum_q;

endmodule
